// File: rtl/dmem_req_ctrl_if.sv
// Data SRAM bus between dmem_req_ctrl (master) and the data memory (slave):
// req/addr_ok/data_ok handshake with byte strobes.
interface dmem_req_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: one EX-stage load/store to one SRAM bus transaction.
// Define DMEM_WBUF_EN for a one-entry posted write buffer (stores do not stall).
module dmem_req_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_wr,
    input  logic [1:0]             req_size,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   stall_req,
    output logic                   excp_adel,
    output logic                   excp_ades,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic [3:0]             resp_sel,
    dmem_req_ctrl_if.master        bus
);

`ifdef DMEM_WBUF_EN
    localparam bit WbufEn = 1'b1;
`else
    localparam bit WbufEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e      state;
    logic        req_q;
    logic        wr_q;
    logic [3:0]  strb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [3:0]  strb;
    logic [31:0] wdata_rep;
    logic        misaligned;
    logic        accept;
    logic        complete;
    logic        store_busy;
    logic        req_live;

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_wstrb = strb_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

    always_comb begin
        strb       = 4'b1111;
        wdata_rep  = req_wdata;
        misaligned = |req_addr[1:0];
        unique case (req_size)
            2'd0: begin
                strb       = 4'b0001 << req_addr[1:0];
                wdata_rep  = {4{req_wdata[7:0]}};
                misaligned = 1'b0;
            end
            2'd1: begin
                strb       = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{req_wdata[15:0]}};
                misaligned = req_addr[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        accept     = (state == StIdle) && req_valid && !misaligned;
        complete   = ((state == StReq) && bus.data_addr_ok && bus.data_data_ok) ||
                     ((state == StWait) && bus.data_data_ok);
        // A draining posted store lets the pipeline keep presenting new requests.
        store_busy = WbufEn && (state != StIdle) && wr_q;
        req_live   = req_valid && ((state == StIdle) || store_busy);
        excp_adel  = req_live && misaligned && !req_wr;
        excp_ades  = req_live && misaligned && req_wr;
        if (state == StIdle) begin
            stall_req = accept && !(WbufEn && req_wr);
        end else if (store_busy) begin
            stall_req = req_valid && !misaligned;
        end else begin
            stall_req = !complete;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            strb_q     <= 4'b0;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_sel   <= 4'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        state   <= StReq;
                        req_q   <= 1'b1;
                        wr_q    <= req_wr;
                        strb_q  <= strb;
                        addr_q  <= {req_addr[31:2], 2'b00};
                        wdata_q <= wdata_rep;
                    end
                end
                StReq: begin
                    if (bus.data_addr_ok) begin
                        req_q <= 1'b0;
                        state <= bus.data_data_ok ? StIdle : StWait;
                    end
                end
                StWait: begin
                    if (bus.data_data_ok) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
            if (complete && !wr_q) begin
                resp_valid <= 1'b1;
                resp_rdata <= bus.data_rdata;
                resp_sel   <= strb_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: transaction-queue reference model,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_dmem_req_ctrl;

`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_req;
    logic        excp_adel;
    logic        excp_ades;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_sel;

    dmem_req_ctrl_if bus ();

    dmem_req_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall_req  (stall_req),
        .excp_adel  (excp_adel),
        .excp_ades  (excp_ades),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_sel   (resp_sel),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        wr;
    } txn_t;

    int          n_checks = 0;
    int          n_errors = 0;
    txn_t        pend[$];
    bit          addr_taken;
    logic        m_rv;
    logic [31:0] m_rdata;
    logic [3:0]  m_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mis_f(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] strb_f(input logic [1:0] sz, input logic [31:0] a);
        int unsigned s;
        if (sz == 2'd0) s = 1 << (a % 4);
        else if (sz == 2'd1) s = 3 << (a & 2);
        else s = 15;
        return s[3:0];
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // One clock cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic step(input logic r, input logic v, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic aok,
                        input logic dok, input logic [31:0] rd);
        bit   idle, mis, drain, done, e_stall, e_adel, e_ades;
        txn_t t;
        @(negedge clk);
        rst = r; req_valid = v; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
        bus.data_addr_ok = aok; bus.data_data_ok = dok; bus.data_rdata = rd;
        #1;
        if (r) begin
            pend.delete();
            addr_taken = 1'b0;
            m_rv = 1'b0; m_rdata = '0; m_sel = '0;
            return;
        end
        idle  = (pend.size() == 0);
        mis   = mis_f(sz, a);
        drain = !idle && WBUF && pend[0].wr;
        done  = !idle && (addr_taken ? dok : (aok && dok));
        if (idle || drain) begin
            e_adel = v && mis && !wr;
            e_ades = v && mis && wr;
            e_stall = idle ? (v && !mis && !(WBUF && wr)) : (v && !mis);
        end else begin
            e_adel = 1'b0;
            e_ades = 1'b0;
            e_stall = !done;
        end
        chk("stall_req", 32'(stall_req), 32'(e_stall));
        chk("excp_adel", 32'(excp_adel), 32'(e_adel));
        chk("excp_ades", 32'(excp_ades), 32'(e_ades));
        chk("data_req", 32'(bus.data_req), 32'(!idle && !addr_taken));
        chk("resp_valid", 32'(resp_valid), 32'(m_rv));
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_sel", 32'(resp_sel), 32'(m_sel));
        if (!idle && !addr_taken) begin
            chk("data_addr", bus.data_addr, pend[0].addr);
            chk("data_wstrb", 32'(bus.data_wstrb), 32'(pend[0].strb));
            chk("data_wdata", bus.data_wdata, pend[0].wdata);
            chk("data_wr", 32'(bus.data_wr), 32'(pend[0].wr));
        end
        m_rv = 1'b0;
        if (idle) begin
            if (v && !mis) begin
                t.addr = a & ~32'h3; t.strb = strb_f(sz, a);
                t.wdata = wdata_f(sz, wd); t.wr = wr;
                pend.push_back(t);
                addr_taken = 1'b0;
            end
        end else if (done) begin
            if (!pend[0].wr) begin
                m_rv = 1'b1; m_rdata = rd; m_sel = pend[0].strb;
            end
            pend.delete(0);
            addr_taken = 1'b0;
        end else if (aok) begin
            addr_taken = 1'b1;
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_addr"}, bus.data_addr, 32'h0);
        chk({tag, "_data_wstrb"}, 32'(bus.data_wstrb), 32'h0);
        chk({tag, "_data_wdata"}, bus.data_wdata, 32'h0);
        chk({tag, "_data_wr"}, 32'(bus.data_wr), 32'h0);
        chk({tag, "_data_req"}, 32'(bus.data_req), 32'h0);
        chk({tag, "_stall"}, 32'(stall_req), 32'h0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_resp_sel"}, 32'(resp_sel), 32'h0);
    endtask

    int n_req, n_stall;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
        req_addr = '0; req_wdata = '0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle_step();
        check_all_zero("reset");

        // Aligned word load, fastest bus.
        step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_1004, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("lw_accept_stall", 32'(stall_req), 32'h1);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("lw_addr", bus.data_addr, 32'h0000_1004);
        chk("lw_wstrb", 32'(bus.data_wstrb), 32'hF);
        chk("lw_done_stall", 32'(stall_req), 32'h0);
        idle_step();
        chk("lw_resp_valid", 32'(resp_valid), 32'h1);
        chk("lw_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("lw_resp_sel", 32'(resp_sel), 32'hF);

        // Byte store to lane 2.
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_0102, 32'h0000_00A5, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("sb_wstrb", 32'(bus.data_wstrb), 32'h4);
        chk("sb_wdata", bus.data_wdata, 32'hA5A5_A5A5);
        chk("sb_wr", 32'(bus.data_wr), 32'h1);
        idle_step();
        chk("sb_no_resp", 32'(resp_valid), 32'h0);

        // Misaligned half load.
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0201, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("lh_mis_adel", 32'(excp_adel), 32'h1);
        chk("lh_mis_stall", 32'(stall_req), 32'h0);
        idle_step();
        chk("lh_mis_adel_off", 32'(excp_adel), 32'h0);
        chk("lh_mis_req", 32'(bus.data_req), 32'h0);
        chk("lh_mis_resp", 32'(resp_valid), 32'h0);

        // Load with addr_ok 3 cycles late and data_ok 2 cycles after that.
        n_req = 0; n_stall = 0;
        step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_3008, 32'h0, 1'b0, 1'b0, 32'h0);
        n_stall += int'(stall_req);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, i == 3, i == 5,
                 (i == 5) ? 32'h1234_5678 : 32'h0);
            n_req += int'(bus.data_req);
            n_stall += int'(stall_req);
            if (bus.data_req) chk("slow_addr", bus.data_addr, 32'h0000_3008);
        end
        chk("slow_req_cycles", 32'(n_req), 32'd4);
        chk("slow_stall_cycles", 32'(n_stall), 32'd6);
        idle_step();
        chk("slow_resp_rdata", resp_rdata, 32'h1234_5678);

        // Reset while waiting for data_ok.
        step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_5000, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle_step();
        check_all_zero("rst_wait");
        step(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_6002, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D);
        idle_step();
        chk("post_rst_rdata", resp_rdata, 32'hCAFE_F00D);
        chk("post_rst_sel", 32'(resp_sel), 32'hC);

`ifdef DMEM_WBUF_EN
        // Posted store followed at once by a load; store data_ok 3 cycles after accept.
        step(1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_4000, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
        chk("wbuf_sw_stall", 32'(stall_req), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_4010, 32'h0, i == 1, i == 3, 32'h0);
            chk("wbuf_lw_held", 32'(stall_req), 32'h1);
        end
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h7777_8888);
        chk("wbuf_lw_addr", bus.data_addr, 32'h0000_4010);
        chk("wbuf_lw_done", 32'(stall_req), 32'h0);
        idle_step();
        chk("wbuf_lw_rdata", resp_rdata, 32'h7777_8888);
`endif

        // Randomized traffic with random bus delays and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            logic aok, dok;
            logic [31:0] a;
            a = {18'h0, 12'($urandom)} | ($urandom % 4);
            if (pend.size() == 0) begin
                aok = 1'b0;
                dok = ($urandom % 8) == 0;
            end else if (!addr_taken) begin
                aok = ($urandom % 3) == 0;
                dok = aok && (($urandom % 2) == 0);
            end else begin
                aok = 1'b0;
                dok = ($urandom % 3) == 0;
            end
            step(($urandom % 250) == 0, ($urandom % 5) < 3, 1'($urandom), 2'($urandom), a,
                 $urandom, aok, dok, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
